regfile_scoreboard: RTL and testbench
=====================================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameters SHALL be: none; widths fixed at RegWidth=32, RegAddrWidth=5, 32 architectural registers.
REQ-002 clk  in  1  sole clock; all state updates on posedge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 wb_reg_write_en  in  1  writeback write strobe.
REQ-005 wb_reg_write_addr  in  5  writeback destination.
REQ-006 wb_reg_write_data  in  32  writeback value.
REQ-007 reg_read_en1 / reg_read_en2  in  1 each  read port enables.
REQ-008 reg_read_addr1 / reg_read_addr2  in  5 each  read addresses.
REQ-009 reg_read_data1 / reg_read_data2  out  32 each  read values, combinational.
REQ-010 id_issue_en  in  1  decode issued an instruction that will write a register.
REQ-011 id_issue_addr  in  5  destination of the issued instruction.
REQ-012 flush  in  1  pipeline flush; discards all outstanding reservations.
REQ-013 reg_busy1 / reg_busy2  out  1 each  operand still pending.
REQ-014 stall  out  1  decode must hold.
REQ-015 sb_overflow  out  1  sticky error flag.

Function
REQ-016 Storage SHALL be 32x32-bit registers; register 0 SHALL read 0 always, and writes to address 0 SHALL be discarded.
REQ-017 Write: wb_reg_write_en=1 and addr!=0 -> regs[addr] <= data at posedge.
REQ-018 Read port n: read_en=0 or addr=0 -> 0; else write-en & addr match with wb port (addr!=0) -> wb_reg_write_data (same-cycle bypass); else regs[addr].
REQ-019 Scoreboard: one 2-bit counter cnt[r] per register r=1..31 of in-flight writes; cnt[0] SHALL be constant 0.
REQ-020 Per posedge, r!=0: inc = id_issue_en & id_issue_addr==r; dec = wb_reg_write_en & wb_reg_write_addr==r & cnt[r]!=0.
REQ-021 inc & !dec -> cnt+1; dec & !inc -> cnt-1; both -> unchanged; neither -> unchanged.
REQ-022 inc & !dec with cnt[r]=3 -> cnt stays 3 and sb_overflow <= 1 (sticky until reset).
REQ-023 dec with cnt[r]=0 SHALL not occur (dec gated); writes with cnt 0 SHALL still update storage.
REQ-024 flush=1 -> all cnt <= 0 at posedge, overriding inc/dec same cycle; storage write same cycle SHALL still occur.
REQ-025 reg_busyN = read_enN & addrN!=0 & eff_cnt!=0, where eff_cnt = cnt[addrN] minus 1 if the wb port writes addrN this cycle (and cnt!=0); same-cycle issue SHALL not affect busy (effective next cycle).
REQ-026 stall = reg_busy1 | reg_busy2; no registered latency.
REQ-027 A stalled decode SHALL keep id_issue_en low; the block does not gate id_issue_en with stall.

Reset
REQ-028 rst=0 SHALL asynchronously clear all 31 registers to 0, all cnt to 0, sb_overflow to 0.
REQ-029 While rst=0: reg_read_data1/2=0, reg_busy1/2=0, stall=0; writes and issues ignored.
REQ-030 Reset deassertion SHALL take effect at the first posedge after rst rises; no other synchronization inside the block.

Verification
REQ-031 Reset mid-operation: cnt[5]=2, regs[5]=0xA5A5A5A5, pull rst low between edges -> read of r5 returns 0 immediately, busy 0, stall 0.
REQ-032 Bypass: regs[3]=0x11; cycle with wb write r3=0x22 and read_addr1=3 -> reg_read_data1=0x22 same cycle; next cycle regs[3]=0x22.
REQ-033 Zero register: write r0=0xFFFFFFFF, issue r0 -> read r0=0, busy 0, cnt[0] unchanged.
REQ-034 Scoreboard: issue r7 twice (cnt=2), read r7 -> stall=1; first wb r7 -> stall still 1 that cycle; second wb r7 -> stall 0 same cycle, data=second value.
REQ-035 Simultaneous: cnt[9]=1, issue r9 and wb r9 same cycle -> cnt stays 1, busy r9 read next cycle =1; overflow: cnt[4]=3 plus issue r4 -> cnt 3, sb_overflow=1 held.
REQ-036 Flush: cnt[2]=1, cnt[12]=3, flush with issue r2 same cycle -> all cnt 0 next cycle, stall 0.

Source files
------------

// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: register file / scoreboard bus
// master: pipeline side (drives writeback, reads, issue, flush)
// slave : regfile_scoreboard (returns read data, busy, stall, overflow)
interface regfile_scoreboard_if;
  logic        wb_reg_write_en;
  logic [4:0]  wb_reg_write_addr;
  logic [31:0] wb_reg_write_data;
  logic        reg_read_en1;
  logic        reg_read_en2;
  logic [4:0]  reg_read_addr1;
  logic [4:0]  reg_read_addr2;
  logic [31:0] reg_read_data1;
  logic [31:0] reg_read_data2;
  logic        id_issue_en;
  logic [4:0]  id_issue_addr;
  logic        flush;
  logic        reg_busy1;
  logic        reg_busy2;
  logic        stall;
  logic        sb_overflow;
  modport master (
    output wb_reg_write_en, wb_reg_write_addr, wb_reg_write_data,
    output reg_read_en1, reg_read_en2, reg_read_addr1, reg_read_addr2,
    output id_issue_en, id_issue_addr, flush,
    input  reg_read_data1, reg_read_data2, reg_busy1, reg_busy2, stall, sb_overflow
  );
  modport slave (
    input  wb_reg_write_en, wb_reg_write_addr, wb_reg_write_data,
    input  reg_read_en1, reg_read_en2, reg_read_addr1, reg_read_addr2,
    input  id_issue_en, id_issue_addr, flush,
    output reg_read_data1, reg_read_data2, reg_busy1, reg_busy2, stall, sb_overflow
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 32x32 register file with writeback bypass and per-register in-flight write scoreboard
// clk : sole clock
// rst : asynchronous active-low reset
// sb  : slave bus -- writeback port, two read ports, issue/flush, busy/stall/overflow outputs
module regfile_scoreboard (
  input  logic               clk,
  input  logic               rst,
  regfile_scoreboard_if.slave sb
);
  logic [31:0] regs [32];
  logic [1:0]  cnt  [32];
  logic        ovf;
  logic        wb_hit;
  logic [31:0] inc;
  logic [31:0] dec;
  logic [1:0]  eff1;
  logic [1:0]  eff2;
  assign wb_hit = sb.wb_reg_write_en && sb.wb_reg_write_addr != 5'd0;
  // one-hot issue/retire vectors; bit 0 never participates
  assign inc = (32'(sb.id_issue_en) << sb.id_issue_addr) & 32'hFFFF_FFFE;
  assign dec = 32'(wb_hit && cnt[sb.wb_reg_write_addr] != 2'd0) << sb.wb_reg_write_addr;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
      ovf <= 1'b0;
    end else begin
      if (wb_hit) regs[sb.wb_reg_write_addr] <= sb.wb_reg_write_data;
      for (int i = 1; i < 32; i++)
        if (sb.flush) cnt[i] <= '0;
        else if (inc[i] && !dec[i]) begin
          if (cnt[i] == 2'd3) ovf <= 1'b1;
          else cnt[i] <= cnt[i] + 2'd1;
        end else if (dec[i] && !inc[i]) cnt[i] <= cnt[i] - 2'd1;
    end
  assign sb.reg_read_data1 = (!rst || !sb.reg_read_en1 || sb.reg_read_addr1 == 5'd0) ? '0 :
                             (wb_hit && sb.wb_reg_write_addr == sb.reg_read_addr1) ? sb.wb_reg_write_data :
                             regs[sb.reg_read_addr1];
  assign sb.reg_read_data2 = (!rst || !sb.reg_read_en2 || sb.reg_read_addr2 == 5'd0) ? '0 :
                             (wb_hit && sb.wb_reg_write_addr == sb.reg_read_addr2) ? sb.wb_reg_write_data :
                             regs[sb.reg_read_addr2];
  // a retiring write this cycle already clears its own reservation for the reader
  assign eff1 = cnt[sb.reg_read_addr1] - {1'b0, dec[sb.reg_read_addr1]};
  assign eff2 = cnt[sb.reg_read_addr2] - {1'b0, dec[sb.reg_read_addr2]};
  assign sb.reg_busy1   = rst && sb.reg_read_en1 && sb.reg_read_addr1 != 5'd0 && eff1 != 2'd0;
  assign sb.reg_busy2   = rst && sb.reg_read_en2 && sb.reg_read_addr2 != 5'd0 && eff2 != 2'd0;
  assign sb.stall       = sb.reg_busy1 || sb.reg_busy2;
  assign sb.sb_overflow = ovf;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed and randomized checks of regfile_scoreboard against a behavioural model
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  regfile_scoreboard_if bus();
  regfile_scoreboard dut (.clk(clk), .rst(rst), .sb(bus));
  int tests = 0;
  int fails = 0;
  logic [31:0] m_regs [32];
  int          m_cnt  [32];
  bit          m_ovf;
  int          wa, ia;
  bit          m_inc, m_dec;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  function automatic void clr();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_cnt[i]  = 0;
    end
    m_ovf = 0;
  endfunction
  function automatic logic [31:0] exp_rd(logic en, logic [4:0] a);
    if (!rst || !en || a == 0) return '0;
    if (bus.wb_reg_write_en && bus.wb_reg_write_addr == a) return bus.wb_reg_write_data;
    return m_regs[a];
  endfunction
  function automatic logic [31:0] exp_busy(logic en, logic [4:0] a);
    int c;
    if (!rst || !en || a == 0) return 0;
    c = m_cnt[a];
    if (bus.wb_reg_write_en && bus.wb_reg_write_addr == a && c > 0) c--;
    return (c > 0) ? 1 : 0;
  endfunction
  initial clr();
  always @(negedge rst) clr();
  always @(posedge clk)
    if (rst) begin
      wa = int'(bus.wb_reg_write_addr);
      ia = int'(bus.id_issue_addr);
      m_inc = bus.id_issue_en && ia != 0;
      m_dec = bus.wb_reg_write_en && wa != 0 && m_cnt[wa] > 0;
      if (bus.wb_reg_write_en && wa != 0) m_regs[wa] = bus.wb_reg_write_data;
      if (bus.flush) for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      else if (!(m_inc && m_dec && ia == wa)) begin
        if (m_dec) m_cnt[wa]--;
        if (m_inc) begin
          if (m_cnt[ia] == 3) m_ovf = 1;
          else m_cnt[ia]++;
        end
      end
    end
  always @(negedge clk) begin
    chk("rdata1", bus.reg_read_data1, exp_rd(bus.reg_read_en1, bus.reg_read_addr1));
    chk("rdata2", bus.reg_read_data2, exp_rd(bus.reg_read_en2, bus.reg_read_addr2));
    chk("busy1", 32'(bus.reg_busy1), exp_busy(bus.reg_read_en1, bus.reg_read_addr1));
    chk("busy2", 32'(bus.reg_busy2), exp_busy(bus.reg_read_en2, bus.reg_read_addr2));
    chk("stall", 32'(bus.stall), exp_busy(bus.reg_read_en1, bus.reg_read_addr1) | exp_busy(bus.reg_read_en2, bus.reg_read_addr2));
    chk("ovf", 32'(bus.sb_overflow), 32'(m_ovf));
  end
  task automatic idle();
    bus.wb_reg_write_en = 0; bus.wb_reg_write_addr = 0; bus.wb_reg_write_data = 0;
    bus.reg_read_en1 = 0; bus.reg_read_addr1 = 0; bus.reg_read_en2 = 0; bus.reg_read_addr2 = 0;
    bus.id_issue_en = 0; bus.id_issue_addr = 0; bus.flush = 0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask
  task automatic look();
    @(negedge clk);
    #1;
  endtask
  task automatic wb(logic [4:0] a, logic [31:0] d);
    bus.wb_reg_write_en = 1; bus.wb_reg_write_addr = a; bus.wb_reg_write_data = d;
  endtask
  task automatic iss(logic [4:0] a);
    bus.id_issue_en = 1; bus.id_issue_addr = a;
  endtask
  task automatic rd1(logic [4:0] a);
    bus.reg_read_en1 = 1; bus.reg_read_addr1 = a;
  endtask
  task automatic rd2(logic [4:0] a);
    bus.reg_read_en2 = 1; bus.reg_read_addr2 = a;
  endtask
  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    rd1(5); wb(5, 32'h1234); iss(5);
    look();
    chk("reset_rdata", bus.reg_read_data1, 32'h0);
    chk("reset_stall", 32'(bus.stall), 32'h0);
    chk("reset_ovf", 32'(bus.sb_overflow), 32'h0);
    step(); rst = 1;
    step(); rd1(5); look();
    chk("reset_ignored_write", bus.reg_read_data1, 32'h0);
    step(); wb(3, 32'h11);
    step(); wb(3, 32'h22); rd1(3); look();
    chk("bypass", bus.reg_read_data1, 32'h22);
    step(); rd1(3); look();
    chk("bypass_next", bus.reg_read_data1, 32'h22);
    step(); wb(0, 32'hFFFF_FFFF); iss(0); rd1(0); rd2(0); look();
    chk("r0_read", bus.reg_read_data1, 32'h0);
    chk("r0_busy", 32'(bus.reg_busy1), 32'h0);
    step(); rd1(0); look();
    chk("r0_busy_next", 32'(bus.reg_busy1), 32'h0);
    step(); iss(7);
    step(); iss(7);
    step(); rd1(7); look();
    chk("sb_stall_cnt2", 32'(bus.stall), 32'h1);
    step(); wb(7, 32'h70); rd1(7); look();
    chk("sb_stall_wb1", 32'(bus.stall), 32'h1);
    step(); wb(7, 32'h77); rd1(7); look();
    chk("sb_stall_wb2", 32'(bus.stall), 32'h0);
    chk("sb_data_wb2", bus.reg_read_data1, 32'h77);
    step(); iss(9);
    step(); iss(9); wb(9, 32'h99); rd1(9); look();
    chk("simul_busy_same", 32'(bus.reg_busy1), 32'h0);
    step(); rd1(9); look();
    chk("simul_busy_next", 32'(bus.reg_busy1), 32'h1);
    step(); wb(9, 32'h9);
    for (int i = 0; i < 3; i++) begin step(); iss(4); end
    step(); look();
    chk("ovf_before", 32'(bus.sb_overflow), 32'h0);
    step(); iss(4);
    step(); look();
    chk("ovf_set", 32'(bus.sb_overflow), 32'h1);
    repeat (3) step();
    look();
    chk("ovf_sticky", 32'(bus.sb_overflow), 32'h1);
    step(); wb(4, 32'h41);
    step(); wb(4, 32'h42); rd2(4); look();
    chk("sat_busy_wb2", 32'(bus.reg_busy2), 32'h1);
    step(); wb(4, 32'h43); rd2(4); look();
    chk("sat_busy_wb3", 32'(bus.reg_busy2), 32'h0);
    step(); iss(2);
    for (int i = 0; i < 3; i++) begin step(); iss(12); end
    step(); bus.flush = 1; iss(2); rd1(2); rd2(12); look();
    chk("flush_stall_before", 32'(bus.stall), 32'h1);
    step(); rd1(2); rd2(12); look();
    chk("flush_stall_after", 32'(bus.stall), 32'h0);
    step(); wb(5, 32'hA5A5_A5A5);
    step(); iss(5);
    step(); iss(5);
    step(); rd1(5); look();
    chk("pre_reset_data", bus.reg_read_data1, 32'hA5A5_A5A5);
    chk("pre_reset_busy", 32'(bus.reg_busy1), 32'h1);
    step(); rd1(5);
    #2 rst = 0;
    #1;
    chk("async_reset_data", bus.reg_read_data1, 32'h0);
    chk("async_reset_busy", 32'(bus.reg_busy1), 32'h0);
    chk("async_reset_stall", 32'(bus.stall), 32'h0);
    chk("async_reset_ovf", 32'(bus.sb_overflow), 32'h0);
    step(); rst = 1;
    step(); rd1(5); look();
    chk("post_reset_data", bus.reg_read_data1, 32'h0);
    chk("post_reset_busy", 32'(bus.reg_busy1), 32'h0);
    repeat (3000) begin
      step();
      bus.flush = ($urandom_range(31) == 0);
      bus.wb_reg_write_en = 1'($urandom_range(1));
      bus.wb_reg_write_addr = 5'($urandom_range(7));
      bus.wb_reg_write_data = $urandom;
      bus.id_issue_en = !bus.flush && $urandom_range(2) == 0;
      bus.id_issue_addr = 5'($urandom_range(7));
      bus.reg_read_en1 = 1'($urandom_range(1));
      bus.reg_read_addr1 = 5'($urandom_range(7));
      bus.reg_read_en2 = 1'($urandom_range(1));
      bus.reg_read_addr2 = 5'($urandom_range(7));
    end
    step();
    look();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
